sa_fifo_ctrl_16x128: RTL

- Valid/ready FIFO controller wrapping one 16x128 registered-read-address RAM (rws type).
- Drives the RAM write port (wa/we/di) and read port (ra/re), and consumes RAM dout.
- Presents a streaming 128-bit push/pop interface with full throughput, backed by a 2-entry output skid buffer.
- Sits between an array feeder/drain stage and the RAM macro; the RAM is instantiated outside the block.

---
 rtl/sa_fifo_ctrl_16x128.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sa_fifo_ctrl_16x128.sv
`default_nettype none
// ============================================================================
// Module      : sa_fifo_ctrl_16x128
// Description : Valid/ready FIFO controller around an external 16x128 RAM
//               with a registered read address. Data is streamed through the
//               RAM and a 2-entry output skid buffer so that one push and one
//               pop can be sustained every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sa_fifo_ctrl_16x128 #(
  parameter int DW       = 128,
  parameter int AW       = 4,
  parameter int OB_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  // push side
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  // pop side
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  // occupancy
  output logic [4:0]    count,
  // RAM write port
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  // RAM read port
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  // power-down bus
  input  logic [31:0]   pwrbus_ram_pd_in,
  output logic [31:0]   ram_pwrbus_pd
);

  // Number of RAM slots; ram_cnt reaching this value means the RAM is full.
  localparam logic [AW:0] c_ram_depth = (AW+1)'(2**AW);
  localparam logic [2:0]  c_ob_depth  = 3'(OB_DEPTH);
  localparam logic [1:0]  c_ob_full   = 2'(OB_DEPTH);

  // Architectural state
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [AW:0]   ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    ob_cnt_q,  ob_cnt_d;
  logic [DW-1:0] ob_head_q, ob_head_d;
  logic [DW-1:0] ob_tail_q, ob_tail_d;

  // Handshake and read-issue decisions
  logic          push;
  logic          pop;
  logic          rd_issue;
  logic [2:0]    ob_committed;

  // Handshakes, read-issue decision and RAM port drive.
  always_comb begin
    in_ready  = (ram_cnt_q != c_ram_depth);
    out_valid = (ob_cnt_q != 2'd0);
    // The reset term keeps the RAM write strobe quiet while reset is held,
    // even though in_ready reads 1 in that state.
    push      = in_valid & in_ready & ~reset;
    pop       = out_valid & out_ready;
    // Skid entries that will be occupied once the in-flight read lands,
    // net of a pop this cycle. A new read is issued only if it will fit.
    ob_committed = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd_issue  = (ram_cnt_q != '0) & (ob_committed < c_ob_depth);

    ram_we    = push;
    ram_wa    = wr_ptr_q;
    ram_di    = in_data;
    ram_re    = rd_issue;
    ram_ra    = rd_ptr_q;

    out_data  = ob_head_q;
    count     = ram_cnt_q + {{AW{1'b0}}, rd_pend_q} + {{(AW-1){1'b0}}, ob_cnt_q};

    ram_pwrbus_pd = pwrbus_ram_pd_in;
  end

  // Pointer, RAM occupancy and read-pending next-state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    rd_pend_d = rd_issue;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A slot is released at the issue edge: the RAM has already latched
    // the read address, and the capture on the next edge samples the old
    // contents even if that slot is rewritten on the same edge.
    ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd_issue};
  end

  // Output skid buffer next-state: capture of RAM data and head advance.
  always_comb begin
    ob_head_d = ob_head_q;
    ob_tail_d = ob_tail_q;
    ob_cnt_d  = ob_cnt_q;
    case ({rd_pend_q, pop})
      2'b01: begin
        // Pop only: tail moves up if present.
        if (ob_cnt_q == c_ob_full) begin
          ob_head_d = ob_tail_q;
        end
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b10: begin
        // Capture only: land in the first free position.
        if (ob_cnt_q == 2'd0) begin
          ob_head_d = ram_dout;
        end else begin
          ob_tail_d = ram_dout;
        end
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b11: begin
        // Capture and pop together: occupancy unchanged.
        if (ob_cnt_q == c_ob_full) begin
          ob_head_d = ob_tail_q;
          ob_tail_d = ram_dout;
        end else begin
          ob_head_d = ram_dout;
        end
      end
      default: begin
        ob_cnt_d = ob_cnt_q;
      end
    endcase
  end

  // State registers with asynchronous reset; RAM contents are untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      ob_cnt_q  <= 2'd0;
      ob_head_q <= '0;
      ob_tail_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_pend_d;
      ob_cnt_q  <= ob_cnt_d;
      ob_head_q <= ob_head_d;
      ob_tail_q <= ob_tail_d;
    end
  end

endmodule
`default_nettype wire
